synaptic_input_accumulator: RTL and testbench

SYNAPTIC_INPUT_ACCUMULATOR -- requirements
Module: synaptic_input_accumulator

---
 rtl/snn_pkg.sv | 23 ++
 rtl/synapse_weight_regfile.sv | 31 +++
 rtl/synaptic_input_accumulator.sv | 134 +++++++++++++
 tb/tb_synaptic_input_accumulator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and clamp helpers for the spiking-neuron datapath blocks.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_e;

    localparam int CUR_BITS_DEFAULT = 5;

    function automatic int cur_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int cur_min(input int bits);
        return -(1 << (bits - 1));
    endfunction

    localparam int CUR_MAX = cur_max(CUR_BITS_DEFAULT);
    localparam int CUR_MIN = cur_min(CUR_BITS_DEFAULT);

endpackage

// File: rtl/synapse_weight_regfile.sv
// Synaptic weight storage: one write port, one combinational read port, async clear.
module synapse_weight_regfile #(
    parameter int N_INPUTS = 8,
    parameter int W_BITS   = 5,
    localparam int IDX_W   = $clog2(N_INPUTS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we_i,
    input  logic        [IDX_W-1:0]  waddr_i,
    input  logic signed [W_BITS-1:0] wdata_i,
    input  logic        [IDX_W-1:0]  raddr_i,
    output logic signed [W_BITS-1:0] rdata_o
);

    logic signed [W_BITS-1:0] mem_q [N_INPUTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the stored value, so a same-cycle write is only visible next cycle.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synaptic_input_accumulator.sv
// Serial weighted sum of a latched spike vector, one synapse per cycle, saturated to the neuron current width.
module synaptic_input_accumulator
    import snn_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int W_BITS   = 5,
    parameter int CUR_BITS = CUR_BITS_DEFAULT,
    localparam int IDX_W   = $clog2(N_INPUTS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_INPUTS-1:0]        spikes_in,
    input  logic                       spikes_valid,
    input  logic                       weight_we,
    input  logic [IDX_W-1:0]           weight_addr,
    input  logic signed [W_BITS-1:0]   weight_data,
    output logic signed [CUR_BITS-1:0] input_current,
    output logic                       current_valid,
    output logic                       current_saturated,
    output logic                       busy,
    output logic                       dropped
);

    localparam int ACC_BITS = W_BITS + IDX_W;
    localparam int CMAX     = cur_max(CUR_BITS);
    localparam int CMIN     = cur_min(CUR_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    function automatic logic is_clamped(input logic signed [ACC_BITS-1:0] v);
        return (int'(v) > CMAX) || (int'(v) < CMIN);
    endfunction

    function automatic logic signed [CUR_BITS-1:0] clamp(input logic signed [ACC_BITS-1:0] v);
        if (int'(v) > CMAX)      return CUR_BITS'(CMAX);
        else if (int'(v) < CMIN) return CUR_BITS'(CMIN);
        else                     return CUR_BITS'(v);
    endfunction

    acc_state_e                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [ACC_BITS-1:0]  acc_q, acc_d;
    logic [N_INPUTS-1:0]         spk_q, spk_d;
    logic signed [CUR_BITS-1:0]  cur_q, cur_d;
    logic                        sat_q, sat_d;
    logic                        cvld_q, cvld_d;

    logic signed [W_BITS-1:0]    rd_w;
    logic signed [ACC_BITS-1:0]  addend;
    logic signed [ACC_BITS-1:0]  acc_sum;

    synapse_weight_regfile #(
        .N_INPUTS (N_INPUTS),
        .W_BITS   (W_BITS)
    ) u_weights (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (weight_we),
        .waddr_i (weight_addr),
        .wdata_i (weight_data),
        .raddr_i (idx_q),
        .rdata_o (rd_w)
    );

    always_comb begin
        addend = '0;
        if (spk_q[idx_q]) begin
            addend = ACC_BITS'(rd_w);
        end
        acc_sum = acc_q + addend;

        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        spk_d   = spk_q;
        cur_d   = cur_q;
        sat_d   = sat_q;
        cvld_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (spikes_valid) begin
                    spk_d   = spikes_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
                // Result is registered on the last synapse so it is on the outputs during DONE.
                if (idx_q == LAST_IDX) begin
                    cur_d   = clamp(acc_sum);
                    sat_d   = is_clamped(acc_sum);
                    cvld_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            spk_q   <= '0;
            cur_q   <= '0;
            sat_q   <= 1'b0;
            cvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            spk_q   <= spk_d;
            cur_q   <= cur_d;
            sat_q   <= sat_d;
            cvld_q  <= cvld_d;
        end
    end

    assign input_current     = cur_q;
    assign current_valid     = cvld_q;
    assign current_saturated = sat_q;
    assign busy              = (state_q != IDLE);
    assign dropped           = spikes_valid && (state_q != IDLE);

endmodule

// File: tb/tb_synaptic_input_accumulator.sv
// Directed and randomized bench for synaptic_input_accumulator against an arithmetic reference model.
module tb_synaptic_input_accumulator;

    localparam int N  = 8;
    localparam int WB = 5;
    localparam int CB = 5;
    localparam int CMAX = (1 << (CB - 1)) - 1;
    localparam int CMIN = -(1 << (CB - 1));

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic [N-1:0]         spikes_in = '0;
    logic                 spikes_valid = 1'b0;
    logic                 weight_we = 1'b0;
    logic [2:0]           weight_addr = '0;
    logic signed [WB-1:0] weight_data = '0;
    logic signed [CB-1:0] input_current;
    logic                 current_valid;
    logic                 current_saturated;
    logic                 busy;
    logic                 dropped;

    int tests = 0;
    int fails = 0;
    int wts [N];

    synaptic_input_accumulator #(
        .N_INPUTS (N),
        .W_BITS   (WB),
        .CUR_BITS (CB)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .spikes_in         (spikes_in),
        .spikes_valid      (spikes_valid),
        .weight_we         (weight_we),
        .weight_addr       (weight_addr),
        .weight_data       (weight_data),
        .input_current     (input_current),
        .current_valid     (current_valid),
        .current_saturated (current_saturated),
        .busy              (busy),
        .dropped           (dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input int val);
        weight_we   = 1'b1;
        weight_addr = idx[2:0];
        weight_data = val[WB-1:0];
        tick();
        weight_we   = 1'b0;
        wts[idx]    = val;
    endtask

    task automatic set_all(input int val);
        for (int i = 0; i < N; i++) wr(i, val);
    endtask

    // One integration step; optional drop strobe at ACCUM cycle drop_cyc and weight write at cycle wr_cyc.
    task automatic run_step(input string tag, input logic [N-1:0] spk,
                            input int drop_cyc, input int wr_cyc, input int wr_idx, input int wr_val);
        int sum;
        int w;
        int exp_cur;
        int exp_sat;
        int n;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            w = (wr_cyc > 0 && i == wr_idx && i >= wr_cyc) ? wr_val : wts[i];
            if (spk[i]) sum += w;
        end
        exp_cur = (sum > CMAX) ? CMAX : (sum < CMIN) ? CMIN : sum;
        exp_sat = (sum > CMAX || sum < CMIN) ? 1 : 0;

        spikes_in    = spk;
        spikes_valid = 1'b1;
        tick();
        spikes_valid = 1'b0;
        spikes_in    = N'($urandom);
        chk({tag, "_busy"}, 32'(busy), 1);
        n = 1;
        while (n < 20 && !current_valid) begin
            if (n == drop_cyc) begin
                spikes_valid = 1'b1;
                spikes_in    = ~spk;
                #1;
                chk({tag, "_dropped"}, 32'(dropped), 1);
            end
            if (n == wr_cyc) begin
                weight_we   = 1'b1;
                weight_addr = wr_idx[2:0];
                weight_data = wr_val[WB-1:0];
            end
            tick();
            spikes_valid = 1'b0;
            weight_we    = 1'b0;
            #1;
            if (n == drop_cyc) chk({tag, "_dropped_off"}, 32'(dropped), 0);
            n++;
        end
        if (wr_cyc > 0) wts[wr_idx] = wr_val;
        chk({tag, "_latency"}, n, N + 1);
        chk({tag, "_valid"}, 32'(current_valid), 1);
        chk({tag, "_current"}, $signed(input_current), exp_cur);
        chk({tag, "_sat"}, 32'(current_saturated), exp_sat);
        tick();
        chk({tag, "_valid_off"}, 32'(current_valid), 0);
        chk({tag, "_hold"}, $signed(input_current), exp_cur);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic count_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (current_valid) pulses++;
            tick();
        end
        chk(tag, pulses, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) wts[i] = 0;

        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_current", $signed(input_current), 0);
        chk("rst_valid", 32'(current_valid), 0);
        chk("rst_sat", 32'(current_saturated), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dropped", 32'(dropped), 0);
        reset_n = 1'b1;
        tick();
        run_step("rst_ones", 8'hFF, 0, 0, 0, 0);

        set_all(3);
        run_step("plus3", 8'b0000_0101, 0, 0, 0, 0);

        set_all(0);
        wr(0, 7);
        wr(1, -5);
        run_step("mixed", 8'b0000_0011, 0, 0, 0, 0);

        set_all(15);
        run_step("satpos", 8'hFF, 0, 0, 0, 0);
        set_all(-16);
        run_step("satneg", 8'hFF, 0, 0, 0, 0);

        run_step("zero", 8'h00, 0, 0, 0, 0);

        set_all(2);
        run_step("drop", 8'b1010_1010, 3, 0, 0, 0);
        count_quiet("drop_no_second", 12);

        run_step("b2b_a", 8'h0F, 0, 0, 0, 0);
        run_step("b2b_b", 8'hF0, 0, 0, 0, 0);

        for (int i = 0; i < N; i++) wr(i, i - 4);
        run_step("wr_same", 8'hFF, 0, 4, 3, 11);
        run_step("wr_ahead", 8'hFF, 0, 4, 5, -9);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) wr(i, int'($urandom_range(0, 31)) - 16);
            run_step("rand", N'($urandom), 0, 0, 0, 0);
        end

        set_all(5);
        spikes_in    = 8'hFF;
        spikes_valid = 1'b1;
        tick();
        spikes_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(current_valid), 0);
        chk("abort_current", $signed(input_current), 0);
        for (int i = 0; i < N; i++) wts[i] = 0;
        tick();
        reset_n = 1'b1;
        count_quiet("abort_no_valid", 15);
        chk("abort_current_after", $signed(input_current), 0);
        run_step("abort_cleared", 8'hFF, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
